// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing light controller: tick-enabled phase FSM with a latched,
// synchronised pedestrian request, minimum car green, blinking end phase and night mode.
module ped_crossing_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int CNT_W       = 16,
  parameter int T_AG_MIN    = 10,
  parameter int T_AY        = 8,
  parameter int T_AR        = 6,
  parameter int T_PG        = 30,
  parameter int T_PE        = 12,
  parameter int T_ARII      = 9,
  parameter int T_ARY       = 10,
  parameter int BLINK_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       KEY,
  input  logic       NIGHT,
  output logic       P_R,
  output logic       P_G,
  output logic       A_R,
  output logic       A_Y,
  output logic       A_G,
  output logic       KEY_ACK,
  output logic [3:0] STATE
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [3:0] {
    S_START           = 4'd0,
    S_AUTO_GREEN      = 4'd1,
    S_AUTO_YELLOW     = 4'd2,
    S_AUTO_RED        = 4'd3,
    S_PEOPLE_GREEN    = 4'd4,
    S_PEOPLE_END      = 4'd5,
    S_AUTO_REDII      = 4'd6,
    S_AUTO_RED_YELLOW = 4'd7,
    S_NIGHT_BLINK     = 4'd8
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       timer, timer_nxt;
  logic [PW-1:0]          pre_cnt;
  logic                   tick;
  logic [SYNC_STAGES-1:0] key_sync, night_sync;
  logic                   key_s, key_d, night_s, key_rise;
  logic                   req, req_set, req_clr;
  logic                   enter, blink_state, blink_enter;
  logic                   blink;
  logic [BW-1:0]          blink_cnt;
  logic [4:0]             lamps_dec, lamps_p1;

  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      S_AUTO_GREEN:      phase_len = CNT_W'(T_AG_MIN - 1);
      S_AUTO_YELLOW:     phase_len = CNT_W'(T_AY - 1);
      S_AUTO_RED:        phase_len = CNT_W'(T_AR - 1);
      S_PEOPLE_GREEN:    phase_len = CNT_W'(T_PG - 1);
      S_PEOPLE_END:      phase_len = CNT_W'(T_PE - 1);
      S_AUTO_REDII:      phase_len = CNT_W'(T_ARII - 1);
      S_AUTO_RED_YELLOW: phase_len = CNT_W'(T_ARY - 1);
      default:           phase_len = '0;
    endcase
  endfunction

  // Prescaler: tick is high during the last count of each CLK_DIV window.
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST)      pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick = (pre_cnt == PRE_LAST);

  // Input synchronisers plus one extra flop for KEY rising-edge detection.
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      key_sync   <= '0;
      night_sync <= '0;
      key_d      <= 1'b0;
    end else begin
      key_sync   <= {key_sync[SYNC_STAGES-2:0], KEY};
      night_sync <= {night_sync[SYNC_STAGES-2:0], NIGHT};
      key_d      <= key_s;
    end
  end

  assign key_s    = key_sync[SYNC_STAGES-1];
  assign night_s  = night_sync[SYNC_STAGES-1];
  assign key_rise = key_s & ~key_d;

  // Phase sequencing; the timer holds at zero while green waits for a request.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    if (tick) begin
      case (state)
        S_START:           state_nxt = S_AUTO_GREEN;
        S_AUTO_GREEN: begin
          if (timer == '0) begin
            if (night_s)  state_nxt = S_NIGHT_BLINK;
            else if (req) state_nxt = S_AUTO_YELLOW;
          end
        end
        S_AUTO_YELLOW:     if (timer == '0) state_nxt = S_AUTO_RED;
        S_AUTO_RED:        if (timer == '0) state_nxt = S_PEOPLE_GREEN;
        S_PEOPLE_GREEN:    if (timer == '0) state_nxt = S_PEOPLE_END;
        S_PEOPLE_END:      if (timer == '0) state_nxt = S_AUTO_REDII;
        S_AUTO_REDII:      if (timer == '0) state_nxt = S_AUTO_RED_YELLOW;
        S_AUTO_RED_YELLOW: if (timer == '0) state_nxt = S_AUTO_GREEN;
        S_NIGHT_BLINK:     if (!night_s)    state_nxt = S_AUTO_REDII;
        default:           state_nxt = S_START;
      endcase
      if (state_nxt != state) timer_nxt = phase_len(state_nxt);
      else if (timer != '0)   timer_nxt = timer - CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      state <= S_START;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  assign enter       = tick && (state_nxt != state);
  assign blink_state = (state == S_PEOPLE_END) || (state == S_NIGHT_BLINK);
  assign blink_enter = enter && ((state_nxt == S_PEOPLE_END) || (state_nxt == S_NIGHT_BLINK));

  // Request latch: clearing on entry to pedestrian green / night wins over a new press.
  assign req_clr = enter && ((state_nxt == S_PEOPLE_GREEN) || (state_nxt == S_NIGHT_BLINK));
  assign req_set = key_rise && !(state inside {S_PEOPLE_GREEN, S_PEOPLE_END, S_NIGHT_BLINK});

  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST)         req <= 1'b0;
    else if (req_clr) req <= 1'b0;
    else if (req_set) req <= 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (blink_enter) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (tick && blink_state) begin
      if (blink_cnt == BLINK_LAST) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Lamp decode, ordered P_R P_G A_R A_Y A_G.
  always_comb begin
    lamps_dec = 5'b00000;
    case (state)
      S_AUTO_GREEN:      lamps_dec = 5'b10001;
      S_AUTO_YELLOW:     lamps_dec = 5'b10010;
      S_AUTO_RED:        lamps_dec = 5'b10100;
      S_PEOPLE_GREEN:    lamps_dec = 5'b01100;
      S_PEOPLE_END:      lamps_dec = {1'b0, blink, 3'b100};
      S_AUTO_REDII:      lamps_dec = 5'b10100;
      S_AUTO_RED_YELLOW: lamps_dec = 5'b10110;
      S_NIGHT_BLINK:     lamps_dec = {3'b000, blink, 1'b0};
      default:           lamps_dec = 5'b00000;
    endcase
  end

  // Output stage: lamps follow the state register by one CLOCK.
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) lamps_p1 <= 5'b00000;
    else      lamps_p1 <= lamps_dec;
  end

  assign {P_R, P_G, A_R, A_Y, A_G} = lamps_p1;
  assign KEY_ACK = req;
  assign STATE   = state;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed scenarios plus random KEY/NIGHT/reset traffic,
// every CLOCK compared against a phase-duration reference model through a scoreboard queue.
module tb_ped_crossing_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int SYNC      = 2;
  localparam int BLINK_DIV = 2;
  localparam int T_AG_MIN  = 10;
  localparam int T_AY      = 8;
  localparam int T_AR      = 6;
  localparam int T_PG      = 30;
  localparam int T_PE      = 12;
  localparam int T_ARII    = 9;
  localparam int T_ARY     = 10;

  localparam int PH_START = 0, PH_AG = 1, PH_AY = 2, PH_AR = 3, PH_PG = 4;
  localparam int PH_PE = 5, PH_ARII = 6, PH_ARY = 7, PH_NB = 8;

  logic       CLOCK = 1'b0;
  logic       RST   = 1'b0;
  logic       KEY   = 1'b0;
  logic       NIGHT = 1'b0;
  logic       P_R, P_G, A_R, A_Y, A_G, KEY_ACK;
  logic [3:0] STATE;

  ped_crossing_ctrl #(
    .CLK_DIV(CLK_DIV), .CNT_W(16), .T_AG_MIN(T_AG_MIN), .T_AY(T_AY), .T_AR(T_AR),
    .T_PG(T_PG), .T_PE(T_PE), .T_ARII(T_ARII), .T_ARY(T_ARY),
    .BLINK_DIV(BLINK_DIV), .SYNC_STAGES(SYNC)
  ) dut (
    .CLOCK(CLOCK), .RST(RST), .KEY(KEY), .NIGHT(NIGHT),
    .P_R(P_R), .P_G(P_G), .A_R(A_R), .A_Y(A_Y), .A_G(A_G),
    .KEY_ACK(KEY_ACK), .STATE(STATE)
  );

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  int m_phase, m_elapsed, m_cyc;
  bit m_req;
  bit key_h[$];
  bit night_h[$];

  function automatic int dur(int p);
    case (p)
      PH_START: return 1;
      PH_AG:    return T_AG_MIN;
      PH_AY:    return T_AY;
      PH_AR:    return T_AR;
      PH_PG:    return T_PG;
      PH_PE:    return T_PE;
      PH_ARII:  return T_ARII;
      PH_ARY:   return T_ARY;
      default:  return 1;
    endcase
  endfunction

  // Lamps P_R P_G A_R A_Y A_G for a phase; blink is on for the first BLINK_DIV ticks, off the next, ...
  function automatic logic [4:0] lamps(int p, int el);
    logic b;
    b = ((el / BLINK_DIV) % 2) == 0;
    case (p)
      PH_AG:   return 5'b10001;
      PH_AY:   return 5'b10010;
      PH_AR:   return 5'b10100;
      PH_PG:   return 5'b01100;
      PH_PE:   return {1'b0, b, 3'b100};
      PH_ARII: return 5'b10100;
      PH_ARY:  return 5'b10110;
      PH_NB:   return {3'b000, b, 1'b0};
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_reset();
    m_phase   = PH_START;
    m_elapsed = 0;
    m_cyc     = 0;
    m_req     = 1'b0;
    key_h.delete();
    night_h.delete();
    for (int i = 0; i <= SYNC; i++) begin
      key_h.push_back(1'b0);
      night_h.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit tick, ks, kd, ns, last, set_r, clr_r;
    int nxt;
    logic [4:0] lmp;
    m_cyc++;
    tick = (m_cyc % CLK_DIV) == 0;
    ks = key_h[SYNC-1];
    kd = key_h[SYNC];
    ns = night_h[SYNC-1];
    nxt = m_phase;
    if (tick) begin
      last = m_elapsed >= dur(m_phase) - 1;
      case (m_phase)
        PH_START: nxt = PH_AG;
        PH_AG:    if (last) begin
                    if (ns) nxt = PH_NB;
                    else if (m_req) nxt = PH_AY;
                  end
        PH_AY:    if (last) nxt = PH_AR;
        PH_AR:    if (last) nxt = PH_PG;
        PH_PG:    if (last) nxt = PH_PE;
        PH_PE:    if (last) nxt = PH_ARII;
        PH_ARII:  if (last) nxt = PH_ARY;
        PH_ARY:   if (last) nxt = PH_AG;
        PH_NB:    if (!ns) nxt = PH_ARII;
        default:  nxt = PH_START;
      endcase
    end
    set_r = ks && !kd && !(m_phase == PH_PG || m_phase == PH_PE || m_phase == PH_NB);
    clr_r = (nxt != m_phase) && (nxt == PH_PG || nxt == PH_NB);
    lmp = lamps(m_phase, m_elapsed);
    if (clr_r) m_req = 1'b0;
    else if (set_r) m_req = 1'b1;
    if (nxt != m_phase) m_elapsed = 0;
    else if (tick) m_elapsed++;
    m_phase = nxt;
    exp_q.push_back({4'(m_phase), m_req, lmp});
    key_h.push_front(KEY);
    void'(key_h.pop_back());
    night_h.push_front(NIGHT);
    void'(night_h.pop_back());
  endtask

  // Reference model: one expectation per CLOCK edge; asynchronous reset replaces the pending one.
  initial begin
    model_reset();
    forever begin
      @(posedge CLOCK or negedge RST);
      if (!RST) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back(10'b0);
      end else begin
        model_step();
      end
    end
  end

  // Monitor: compares the DUT outputs on the falling edge against the queued expectation.
  initial begin
    logic [9:0] e, a;
    forever begin
      @(negedge CLOCK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {STATE, KEY_ACK, P_R, P_G, A_R, A_Y, A_G};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t actual state=%0d ack=%b lamps=%b required state=%0d ack=%b lamps=%b",
                   $time, a[9:6], a[5], a[4:0], e[9:6], e[5], e[4:0]);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic press(int w);
    KEY = 1'b1;
    step(w);
    KEY = 1'b0;
  endtask

  task automatic wait_state(int s, int bound);
    int k;
    k = 0;
    while (STATE !== 4'(s) && k < bound) begin
      step(1);
      k++;
    end
    checks++;
    if (STATE !== 4'(s)) begin
      errors++;
      $display("FAIL wait_state actual=%0d required=%0d within %0d cycles", STATE, s, bound);
    end
  endtask

  initial begin
    step(3);
    RST = 1'b1;
    step(60);
    press(3);
    wait_state(PH_PG, 600);
    wait_state(PH_AG, 600);
    step(8);
    press(3);
    wait_state(PH_PG, 600);
    step(20);
    press(3);
    wait_state(PH_PE, 600);
    step(10);
    press(2);
    wait_state(PH_ARII, 600);
    step(6);
    press(2);
    wait_state(PH_AG, 600);
    wait_state(PH_AY, 200);
    wait_state(PH_AG, 1000);
    step(800);
    press(3);
    wait_state(PH_PG, 600);
    wait_state(PH_AG, 600);
    step(5);
    NIGHT = 1'b1;
    press(3);
    wait_state(PH_NB, 200);
    step(100);
    NIGHT = 1'b0;
    wait_state(PH_AG, 500);
    step(20);
    press(3);
    wait_state(PH_PG, 600);
    step(30);
    RST = 1'b0;
    step(3);
    RST = 1'b1;
    step(60);
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        RST = 1'b0;
        step(int'($urandom_range(1, 3)));
        RST = 1'b1;
      end else if (r < 4) begin
        NIGHT = ~NIGHT;
      end else begin
        press(int'($urandom_range(1, 6)));
      end
      step(int'($urandom_range(1, 250)));
    end
    NIGHT = 1'b0;
    step(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
